r5p_tcb_sub_mem: RTL and testbench

R5P_TCB_SUB_MEM -- requirements
Module: r5p_tcb_sub_mem

---
 rtl/tcb_pkg.sv | 9 +
 rtl/tcb_if.sv | 34 +++
 rtl/r5p_tcb_sub_mem_ram.sv | 32 +++
 rtl/r5p_tcb_sub_mem.sv | 132 +++++++++++++
 tb/tb_r5p_tcb_sub_mem.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/tcb_pkg.sv
// Shared TCB bus definitions: endianness encoding used by the request channel.
package tcb_pkg;

    typedef enum logic {
        TCB_LITTLE = 1'b0,
        TCB_BIG    = 1'b1
    } tcb_endian_t;

endpackage : tcb_pkg

// File: rtl/tcb_if.sv
// TCB handshake interface: valid/ready with a request and a response payload.
interface tcb_if
    import tcb_pkg::*;
#(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32
);

    typedef struct packed {
        logic                 wen;
        logic [ABW-1:0]       adr;
        logic [DBW/8-1:0]     ben;
        logic [DBW-1:0]       wdt;
        tcb_endian_t          ndn;
    } req_t;

    typedef struct packed {
        logic err;
    } sts_t;

    typedef struct packed {
        logic [DBW-1:0] rdt;
        sts_t           sts;
    } rsp_t;

    logic vld;
    logic rdy;
    req_t req;
    rsp_t rsp;

    modport man (output vld, output req, input rdy, input rsp);
    modport sub (input vld, input req, output rdy, output rsp);

endinterface : tcb_if

// File: rtl/r5p_tcb_sub_mem_ram.sv
// Word-wide storage with byte-lane synchronous write and asynchronous read;
// kept separate so a vendor RAM macro can be dropped in.
module r5p_tcb_sub_mem_ram #(
    parameter int unsigned IAW = 10,
    parameter int unsigned DBW = 32
)(
    input  logic             clk,
    input  logic             we,
    input  logic [IAW-1:0]   adr,
    input  logic [DBW/8-1:0] ben,
    input  logic [DBW-1:0]   wdt,
    output logic [DBW-1:0]   rdt
);

    localparam int unsigned BEW   = DBW/8;
    localparam int unsigned DEPTH = 1 << IAW;

    logic [DBW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BEW; b++) begin
                if (ben[b]) begin
                    mem[adr][b*8 +: 8] <= wdt[b*8 +: 8];
                end
            end
        end
    end

    assign rdt = mem[adr];

endmodule : r5p_tcb_sub_mem_ram

// File: rtl/r5p_tcb_sub_mem.sv
// TCB subordinate memory: ready FSM with optional wait states, error detection,
// byte-enabled writes and a fixed-latency response pipeline.
module r5p_tcb_sub_mem
    import tcb_pkg::*;
#(
    parameter int unsigned ABW  = 32,
    parameter int unsigned DBW  = 32,
    parameter int unsigned SIZ  = 4096,
    parameter int unsigned DLY  = 1,
    parameter int unsigned WAIT = 0
)(
    input  logic clk,
    input  logic rst,
    tcb_if.sub   bus
);

    localparam int unsigned BEW = DBW/8;
    localparam int unsigned OFF = $clog2(BEW);
    localparam int unsigned MAW = $clog2(SIZ);
    localparam int unsigned IAW = MAW - OFF;

    typedef logic [1:0] state_t;
    localparam state_t ST_RST = 2'd0;
    localparam state_t ST_RDY = 2'd1;
    localparam state_t ST_WTS = 2'd2;

    localparam logic [2:0] CNT_LAST = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

    state_t         state_reg, state_next;
    logic [2:0]     cnt_reg, cnt_next;
    logic           trn;
    logic           err;
    logic [IAW-1:0] idx;
    logic [DBW-1:0] ram_rdt;
    logic [DBW-1:0] rsp_rdt;

    assign bus.rdy = (state_reg == ST_RDY);
    assign trn     = bus.vld & bus.rdy;

    // Out-of-range addresses alias onto the array, so the error flag must gate writes.
    assign idx = bus.req.adr[MAW-1:OFF];
    assign err = (64'(bus.req.adr) >= 64'(SIZ)) || (bus.req.ndn != TCB_LITTLE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RST: state_next = ST_RDY;
            ST_RDY: begin
                if (trn && (WAIT > 0)) begin
                    state_next = ST_WTS;
                    cnt_next   = 3'd0;
                end
            end
            ST_WTS: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_RDY;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            default: state_next = ST_RST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RST;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    r5p_tcb_sub_mem_ram #(
        .IAW (IAW),
        .DBW (DBW)
    ) u_ram (
        .clk (clk),
        .we  (trn & bus.req.wen & ~err),
        .adr (idx),
        .ben (bus.req.ben),
        .wdt (bus.req.wdt),
        .rdt (ram_rdt)
    );

    // Reads see the asynchronous array output, so a write on the previous edge is already visible.
    assign rsp_rdt = (bus.req.wen || err) ? '0 : ram_rdt;

    // Each stage only advances its payload when a valid response passes through,
    // which makes the last stage hold its value between responses.
    genvar gi;
    generate
        for (gi = 0; gi < DLY; gi++) begin : g_pipe
            logic           in_vld;
            logic [DBW-1:0] in_rdt;
            logic           in_err;
            logic           vld_reg;
            logic [DBW-1:0] rdt_reg;
            logic           err_reg;

            if (gi == 0) begin : g_head
                assign in_vld = trn;
                assign in_rdt = rsp_rdt;
                assign in_err = err;
            end else begin : g_tail
                assign in_vld = g_pipe[gi-1].vld_reg;
                assign in_rdt = g_pipe[gi-1].rdt_reg;
                assign in_err = g_pipe[gi-1].err_reg;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg <= 1'b0;
                    rdt_reg <= '0;
                    err_reg <= 1'b0;
                end else begin
                    vld_reg <= in_vld;
                    if (in_vld) begin
                        rdt_reg <= in_rdt;
                        err_reg <= in_err;
                    end
                end
            end
        end
    endgenerate

    assign bus.rsp.rdt     = g_pipe[DLY-1].rdt_reg;
    assign bus.rsp.sts.err = g_pipe[DLY-1].err_reg;

endmodule : r5p_tcb_sub_mem

// File: tb/tb_r5p_tcb_sub_mem.sv
// Directed bench: DUT A (DLY=1, WAIT=0) for data paths, DUT B (DLY=2, WAIT=2) for timing and reset.
module tb_r5p_tcb_sub_mem;
    import tcb_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tcb_if #(.ABW(32), .DBW(32)) bus_a ();
    tcb_if #(.ABW(32), .DBW(32)) bus_b ();

    r5p_tcb_sub_mem #(
        .ABW(32), .DBW(32), .SIZ(4096), .DLY(1), .WAIT(0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    r5p_tcb_sub_mem #(
        .ABW(32), .DBW(32), .SIZ(4096), .DLY(2), .WAIT(2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer on DUT A: drive, confirm ready, clock it, check the DLY=1 response.
    task automatic a_xfer(input string tag, input logic wen, input logic [31:0] adr,
                          input logic [3:0] ben, input logic [31:0] wdt, input logic ndn,
                          input logic [31:0] exp_rdt, input logic exp_err);
        bus_a.vld     = 1'b1;
        bus_a.req.wen = wen;
        bus_a.req.adr = adr;
        bus_a.req.ben = ben;
        bus_a.req.wdt = wdt;
        bus_a.req.ndn = tcb_endian_t'(ndn);
        check({tag, "_rdy"}, 64'(bus_a.rdy), 64'(1));
        tick();
        bus_a.vld = 1'b0;
        check({tag, "_rdt"}, 64'(bus_a.rsp.rdt), 64'(exp_rdt));
        check({tag, "_err"}, 64'(bus_a.rsp.sts.err), 64'(exp_err));
        $display("xfer %s wen=%0d adr=%h ben=%h wdt=%h rdt=%h err=%0d",
                 tag, wen, adr, ben, wdt, bus_a.rsp.rdt, bus_a.rsp.sts.err);
    endtask

    logic        b_wen [3];
    logic [31:0] b_adr [3];
    logic [31:0] b_rdt [3];
    logic        b_err [3];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_a.vld = 1'b0;
        bus_a.req = '0;
        bus_b.vld = 1'b0;
        bus_b.req = '0;

        // reset and release
        tick();
        check("rst_rdy_a", 64'(bus_a.rdy), 64'(0));
        check("rst_rdt_a", 64'(bus_a.rsp.rdt), 64'(0));
        check("rst_err_a", 64'(bus_a.rsp.sts.err), 64'(0));
        check("rst_rdy_b", 64'(bus_b.rdy), 64'(0));
        rst = 1'b0;
        check("rel_rdy_a0", 64'(bus_a.rdy), 64'(0));
        tick();
        check("rel_rdy_a1", 64'(bus_a.rdy), 64'(1));
        check("rel_rdt_a1", 64'(bus_a.rsp.rdt), 64'(0));
        check("rel_err_a1", 64'(bus_a.rsp.sts.err), 64'(0));
        check("rel_rdy_b1", 64'(bus_b.rdy), 64'(1));

        // back-to-back write then read of the same word
        a_xfer("wr10",  1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        a_xfer("rd10",  1'b0, 32'h10, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
        a_xfer("rd13",  1'b0, 32'h13, 4'h1, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        check("hold_rdt", 64'(bus_a.rsp.rdt), 64'(32'hDEADBEEF));

        // partial byte-enable writes
        a_xfer("wr20",  1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0);
        a_xfer("wr20b2",1'b1, 32'h20, 4'h2, 32'h0000AA00, 1'b0, 32'h0, 1'b0);
        a_xfer("rd20a", 1'b0, 32'h20, 4'hF, 32'h0,        1'b0, 32'h1122AA44, 1'b0);
        a_xfer("wr20b9",1'b1, 32'h20, 4'h9, 32'hCC5566DD, 1'b0, 32'h0, 1'b0);
        a_xfer("rd20b", 1'b0, 32'h20, 4'h0, 32'h0,        1'b0, 32'hCC22AADD, 1'b0);

        // out-of-range and big-endian requests
        a_xfer("wr00",  1'b1, 32'h0,    4'hF, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        a_xfer("rdoor", 1'b0, 32'h1000, 4'hF, 32'h0,        1'b0, 32'h0, 1'b1);
        a_xfer("wroor", 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
        a_xfer("rd00",  1'b0, 32'h0,    4'hF, 32'h0,        1'b0, 32'h0BADF00D, 1'b0);
        a_xfer("wrbig", 1'b1, 32'h10,   4'hF, 32'h12345678, 1'b1, 32'h0, 1'b1);
        a_xfer("rdbig", 1'b0, 32'h10,   4'hF, 32'h0,        1'b1, 32'h0, 1'b1);
        a_xfer("rd10b", 1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);

        // DUT B: vld held high, transfers every 3rd cycle, responses 2 cycles later
        b_wen[0] = 1'b1; b_adr[0] = 32'h40;   b_rdt[0] = 32'h0;        b_err[0] = 1'b0;
        b_wen[1] = 1'b0; b_adr[1] = 32'h40;   b_rdt[1] = 32'h55AA1234; b_err[1] = 1'b0;
        b_wen[2] = 1'b0; b_adr[2] = 32'h1000; b_rdt[2] = 32'h0;        b_err[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            int k;
            logic [31:0] er;
            logic        ee;
            k = i / 3;
            bus_b.vld     = 1'b1;
            bus_b.req.wen = b_wen[k];
            bus_b.req.adr = b_adr[k];
            bus_b.req.ben = 4'hF;
            bus_b.req.wdt = 32'h55AA1234;
            bus_b.req.ndn = TCB_LITTLE;
            check($sformatf("b_rdy_%0d", i), 64'(bus_b.rdy), 64'((i % 3) == 0));
            tick();
            if ((i % 3) == 0) begin
                er = (k == 0) ? 32'h0 : b_rdt[k-1];
                ee = (k == 0) ? 1'b0  : b_err[k-1];
            end else begin
                er = b_rdt[k];
                ee = b_err[k];
            end
            check($sformatf("b_rdt_%0d", i), 64'(bus_b.rsp.rdt), 64'(er));
            check($sformatf("b_err_%0d", i), 64'(bus_b.rsp.sts.err), 64'(ee));
            $display("cycle b%0d vld=1 rdt=%h err=%0d", i, bus_b.rsp.rdt, bus_b.rsp.sts.err);
        end

        // DUT B: reset one cycle after a read transfer discards its response
        bus_b.req.wen = 1'b0;
        bus_b.req.adr = 32'h40;
        check("b_rdy_9", 64'(bus_b.rdy), 64'(1));
        tick();
        bus_b.vld = 1'b0;
        rst = 1'b1;
        #1;
        check("b_rst_rdt", 64'(bus_b.rsp.rdt), 64'(0));
        check("b_rst_err", 64'(bus_b.rsp.sts.err), 64'(0));
        tick();
        rst = 1'b0;
        check("b_rel_rdy0", 64'(bus_b.rdy), 64'(0));
        tick();
        check("b_rel_rdy1", 64'(bus_b.rdy), 64'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b_post_rdt_%0d", i), 64'(bus_b.rsp.rdt), 64'(0));
            check($sformatf("b_post_err_%0d", i), 64'(bus_b.rsp.sts.err), 64'(0));
            $display("cycle post%0d rdt=%h err=%0d", i, bus_b.rsp.rdt, bus_b.rsp.sts.err);
        end

        // memory survives reset
        a_xfer("rdkeep", 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hCC22AADD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_r5p_tcb_sub_mem
